// File: rtl/landing_request_queue.sv
// Landing request FIFO feeding the runway allocator: one en pulse per attempt, grant/hold/back-off handshake.
// Optional EMERGENCY_BYPASS_EN: class 2'b11 goes to a one-entry priority slot instead of the FIFO.
module landing_request_queue #(
   parameter int DEPTH      = 8,
   parameter int EN_PULSE   = 2,
   parameter int RETRY_WAIT = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   input  logic [1:0]               req_type,
   output logic                     req_ready,
   output logic [1:0]               d,
   output logic                     en,
   input  logic [3:0]               signal,
   output logic                     grant_valid,
   output logic                     grant_rwy,
   output logic                     retry,
   output logic                     proto_err,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = AW + 1;
   localparam int TMAX  = (EN_PULSE > RETRY_WAIT) ? EN_PULSE : RETRY_WAIT;
   localparam int TW    = $clog2(TMAX + 1);

   typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, BACKOFF} state_t;

   state_t          state_reg, state_next;
   logic [TW-1:0]   timer_reg, timer_next;
   logic [1:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0]   count_reg;
   logic            fifo_full, fifo_push, pop, grant_ok, load_d;
   logic            is_emerg, slot_full, slot_serving;
   logic            en_next, grant_next, rwy_next, retry_next, perr_next;
   logic [1:0]      d_reg, d_src;
   logic            en_reg, grant_reg, rwy_reg, retry_reg, perr_reg, ovf_reg;

`ifdef EMERGENCY_BYPASS_EN
   logic slot_clear;
   assign is_emerg   = (req_type == 2'b11);
   assign slot_clear = grant_ok && slot_serving;

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_full    <= 1'b0;
         slot_serving <= 1'b0;
      end else begin
         if (slot_clear)
            slot_full <= 1'b0;
         else if (req_valid && is_emerg && !slot_full)
            slot_full <= 1'b1;
         if (load_d)
            slot_serving <= slot_full;
      end
   end
`else
   assign is_emerg     = 1'b0;
   assign slot_full    = 1'b0;
   assign slot_serving = 1'b0;
`endif

   assign fifo_full = (count_reg == CW'(DEPTH));
   assign fifo_push = req_valid && !fifo_full && !is_emerg;
   assign req_ready = is_emerg ? !slot_full : !fifo_full;
   // Emergency slot, when occupied, always wins the next issue
   assign d_src     = slot_full ? 2'b11 : mem[rd_ptr_reg];
   assign pop       = grant_ok && !slot_serving;

   always_ff @(posedge clk) begin
      if (fifo_push)
         mem[wr_ptr_reg] <= req_type;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (fifo_push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({fifo_push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_comb begin
      state_next = state_reg;
      timer_next = timer_reg;
      en_next    = 1'b0;
      load_d     = 1'b0;
      grant_ok   = 1'b0;
      grant_next = 1'b0;
      rwy_next   = 1'b0;
      retry_next = 1'b0;
      perr_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (count_reg != '0 || slot_full) begin
               state_next = DRIVE;
               timer_next = '0;
               load_d     = 1'b1;
            end
         end
         DRIVE: begin
            // First DRIVE cycle sets up d; en then stays high for EN_PULSE cycles
            if (timer_reg == TW'(EN_PULSE)) begin
               state_next = SETTLE;
            end else begin
               en_next    = 1'b1;
               timer_next = timer_reg + 1'b1;
            end
         end
         SETTLE: state_next = CHECK;
         CHECK: begin
            timer_next = '0;
            case (signal)
               4'b1010, 4'b1011: begin
                  grant_ok   = 1'b1;
                  grant_next = 1'b1;
                  rwy_next   = signal[0];
                  state_next = IDLE;
               end
               4'b1101: begin
                  retry_next = 1'b1;
                  state_next = BACKOFF;
               end
               default: begin
                  retry_next = 1'b1;
                  perr_next  = 1'b1;
                  state_next = BACKOFF;
               end
            endcase
         end
         BACKOFF: begin
            if ((slot_full && !slot_serving) || timer_reg == TW'(RETRY_WAIT - 1)) begin
               state_next = DRIVE;
               timer_next = '0;
               load_d     = 1'b1;
            end else begin
               timer_next = timer_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         timer_reg <= '0;
         d_reg     <= 2'b00;
         en_reg    <= 1'b0;
         grant_reg <= 1'b0;
         rwy_reg   <= 1'b0;
         retry_reg <= 1'b0;
         perr_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         timer_reg <= timer_next;
         if (load_d)
            d_reg <= d_src;
         en_reg    <= en_next;
         grant_reg <= grant_next;
         rwy_reg   <= rwy_next;
         retry_reg <= retry_next;
         perr_reg  <= perr_next;
         ovf_reg   <= req_valid && !req_ready;
      end
   end

   assign d           = d_reg;
   assign en          = en_reg;
   assign grant_valid = grant_reg;
   assign grant_rwy   = rwy_reg;
   assign retry       = retry_reg;
   assign proto_err   = perr_reg;
   assign overflow    = ovf_reg;
   assign count       = count_reg;

endmodule

// File: tb/tb_landing_request_queue.sv
// Directed bench for landing_request_queue: per-cycle vector table plus hand sequences for wrap, reset and bypass.
module tb_landing_request_queue;

   logic       clk = 1'b0;
   logic       rst, req_valid, req_ready, en, grant_valid, grant_rwy, retry, proto_err, overflow;
   logic [1:0] req_type, d;
   logic [3:0] signal;
   logic [3:0] count;

   int total = 0;
   int bad   = 0;

   landing_request_queue dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_type(req_type), .req_ready(req_ready),
      .d(d), .en(en), .signal(signal), .grant_valid(grant_valid), .grant_rwy(grant_rwy),
      .retry(retry), .proto_err(proto_err), .overflow(overflow), .count(count)
   );

   always #5 clk = ~clk;

   // exp = {en, d, grant_valid, grant_rwy, retry, proto_err, overflow, count, req_ready}
   typedef struct {
      logic        r;
      logic        v;
      logic [1:0]  t;
      logic [3:0]  s;
      logic [12:0] exp;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic r, input logic v, input logic [1:0] t, input logic [3:0] s,
                               input logic e, input logic [1:0] dd, input logic gv, input logic rw,
                               input logic rt, input logic pe, input logic ov, input logic [3:0] c,
                               input logic rdy);
      vec_t x;
      x.r = r; x.v = v; x.t = t; x.s = s;
      x.exp = {e, dd, gv, rw, rt, pe, ov, c, rdy};
      vecs.push_back(x);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end else
         $display("ok   %s: %0h", name, act);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req_valid = 1'b0; req_type = 2'b00;
      step();
      rst = 1'b0;
   endtask

   logic [1:0] model[$];
   logic [3:0] sl [3];
   logic [1:0] exp_d [3];
   int g, extra;
   logic seen;

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_type = 2'b00; signal = 4'b0000;

      // push 01 and grant on A; then push 10: proto error, hold, then B grant
      //  r  v  t     s        en d     gv rw rt pe ov cnt rdy
      add(1, 0, 2'd0, 4'b0000, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1);
      add(0, 1, 2'd1, 4'b0000, 0, 2'd0, 0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 2'd0, 4'b0000, 0, 2'd1, 0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 2'd0, 4'b0000, 1, 2'd1, 0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 2'd0, 4'b0000, 1, 2'd1, 0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 2'd0, 4'b1010, 0, 2'd1, 0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 2'd0, 4'b1010, 0, 2'd1, 0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 2'd0, 4'b1010, 0, 2'd1, 1, 0, 0, 0, 0, 0, 1);
      add(0, 0, 2'd0, 4'b0000, 0, 2'd1, 0, 0, 0, 0, 0, 0, 1);
      add(0, 1, 2'd2, 4'b0000, 0, 2'd1, 0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 2'd0, 4'b0000, 0, 2'd2, 0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 2'd0, 4'b0000, 1, 2'd2, 0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 2'd0, 4'b0000, 1, 2'd2, 0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 2'd0, 4'b0000, 0, 2'd2, 0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 2'd0, 4'b0000, 0, 2'd2, 0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 2'd0, 4'b0000, 0, 2'd2, 0, 0, 1, 1, 0, 1, 1);
      add(0, 0, 2'd0, 4'b0000, 0, 2'd2, 0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 2'd0, 4'b0000, 0, 2'd2, 0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 2'd0, 4'b0000, 0, 2'd2, 0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 2'd0, 4'b0000, 0, 2'd2, 0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 2'd0, 4'b0000, 1, 2'd2, 0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 2'd0, 4'b0000, 1, 2'd2, 0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 2'd0, 4'b0000, 0, 2'd2, 0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 2'd0, 4'b0000, 0, 2'd2, 0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 2'd0, 4'b1101, 0, 2'd2, 0, 0, 1, 0, 0, 1, 1);
      add(0, 0, 2'd0, 4'b0000, 0, 2'd2, 0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 2'd0, 4'b0000, 0, 2'd2, 0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 2'd0, 4'b0000, 0, 2'd2, 0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 2'd0, 4'b0000, 0, 2'd2, 0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 2'd0, 4'b0000, 1, 2'd2, 0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 2'd0, 4'b0000, 1, 2'd2, 0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 2'd0, 4'b0000, 0, 2'd2, 0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 2'd0, 4'b0000, 0, 2'd2, 0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 2'd0, 4'b1011, 0, 2'd2, 1, 1, 0, 0, 0, 0, 1);
      add(0, 0, 2'd0, 4'b0000, 0, 2'd2, 0, 0, 0, 0, 0, 0, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         rst = vecs[i].r; req_valid = vecs[i].v; req_type = vecs[i].t; signal = vecs[i].s;
         step();
         chk($sformatf("row%0d", i),
             {19'd0, en, d, grant_valid, grant_rwy, retry, proto_err, overflow, count, req_ready},
             {19'd0, vecs[i].exp});
      end

      // three requests granted in push order with B, A, B
      do_reset();
      sl[0] = 4'b1011; sl[1] = 4'b1010; sl[2] = 4'b1011;
      exp_d[0] = 2'b00; exp_d[1] = 2'b10; exp_d[2] = 2'b01;
      g = 0;
      for (int cyc = 0; cyc < 100 && g < 3; cyc++) begin
         signal    = sl[g];
         req_valid = (cyc < 3);
         req_type  = (cyc < 3) ? exp_d[cyc] : 2'b00;
         step();
         if (grant_valid) begin
            chk($sformatf("order_d%0d", g), {30'd0, d}, {30'd0, exp_d[g]});
            chk($sformatf("order_rwy%0d", g), {31'd0, grant_rwy}, {31'd0, sl[g][0]});
            g++;
         end
      end
      req_valid = 1'b0;
      chk("order_grants", g, 3);

      // fill, overflow, then drain with pointer wrap
      do_reset();
      signal = 4'b1101;
      model.delete();
      for (int i = 0; i < 8; i++) begin
         req_valid = 1'b1;
         req_type  = i[1:0];
         model.push_back(i[1:0]);
         step();
      end
      chk("full_count", {28'd0, count}, 32'd8);
      chk("full_ready", {31'd0, req_ready}, 32'd0);
      req_type = 2'b11;
      step();
      chk("ovf_pulse", {31'd0, overflow}, 32'd1);
      chk("ovf_count", {28'd0, count}, 32'd8);
      req_valid = 1'b0;
      step();
      chk("ovf_clear", {31'd0, overflow}, 32'd0);
      extra = 0;
      for (int cyc = 0; cyc < 600 && (model.size() > 0 || extra < 9); cyc++) begin
         signal = {3'b101, d[0]};
         if (extra < 9 && req_ready) begin
            req_valid = 1'b1;
            req_type  = 2'($urandom_range(0, 3));
            model.push_back(req_type);
            extra++;
         end else
            req_valid = 1'b0;
         step();
         if (grant_valid) begin
            if (model.size() == 0)
               chk("wrap_extra_grant", 32'd1, 32'd0);
            else begin
               chk("wrap_d", {30'd0, d}, {30'd0, model[0]});
               chk("wrap_rwy", {31'd0, grant_rwy}, {31'd0, model[0][0]});
               void'(model.pop_front());
            end
         end
      end
      req_valid = 1'b0;
      chk("wrap_left", model.size(), 0);
      chk("wrap_count", {28'd0, count}, 32'd0);

      // reset in the middle of DRIVE
      do_reset();
      signal = 4'b1101;
      req_valid = 1'b1; req_type = 2'b10;
      step();
      req_valid = 1'b0;
      seen = 1'b0;
      for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
         if (en) seen = 1'b1;
         else step();
      end
      chk("rst_en_seen", {31'd0, seen}, 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_en", {31'd0, en}, 32'd0);
      chk("rst_count", {28'd0, count}, 32'd0);

`ifdef EMERGENCY_BYPASS_EN
      // emergency request preempts a FIFO head sitting in BACKOFF
      do_reset();
      signal = 4'b1101;
      req_valid = 1'b1; req_type = 2'b00;
      step();
      req_valid = 1'b0;
      seen = 1'b0;
      for (int cyc = 0; cyc < 30 && !seen; cyc++) begin
         step();
         if (retry) seen = 1'b1;
      end
      chk("byp_backoff", {31'd0, seen}, 32'd1);
      chk("byp_ready", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_type = 2'b11;
      step();
      req_valid = 1'b0;
      signal = 4'b1010;
      seen = 1'b0;
      for (int cyc = 0; cyc < 30 && !seen; cyc++) begin
         step();
         if (grant_valid) seen = 1'b1;
      end
      chk("byp_grant", {31'd0, seen}, 32'd1);
      chk("byp_d", {30'd0, d}, 32'd3);
      chk("byp_count", {28'd0, count}, 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
